alu_reservation_station: RTL and testbench

Eight-entry reservation station feeding the integer ALU in the Tomasulo core. It buffers dispatched ALU/branch micro-ops and captures operands broadcast on two result buses (ALU and load buffer). Each cycle it issues the lowest-index ready entry to the combinational ALU through registered outputs. Tag 0 means "no producer / no result" everywhere, matching the ROB convention.

---
 rtl/alu_reservation_station.sv | 190 +++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU. It buffers dispatched micro-ops, snoops the
// ALU and load CDBs for missing operands, and issues the lowest-index ready entry each cycle.
module alu_reservation_station #(
    parameter int              RS_SIZE = 8,
    parameter int              XLEN    = 32,
    parameter int              ROB_W   = 4,
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] NOP_OP  = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,

    input  logic              disp_valid_in,
    input  logic [OP_W-1:0]   disp_opcode_in,
    input  logic [XLEN-1:0]   disp_vj_in,
    input  logic [XLEN-1:0]   disp_vk_in,
    input  logic [ROB_W-1:0]  disp_qj_in,
    input  logic [ROB_W-1:0]  disp_qk_in,
    input  logic [XLEN-1:0]   disp_a_in,
    input  logic [XLEN-1:0]   disp_pc_in,
    input  logic [ROB_W-1:0]  disp_dest_in,
    output logic              rs_full_out,

    input  logic [ROB_W-1:0]  alu_cdb_h_in,
    input  logic [XLEN-1:0]   alu_cdb_result_in,
    input  logic [ROB_W-1:0]  lsb_cdb_h_in,
    input  logic [XLEN-1:0]   lsb_cdb_result_in,

    input  logic              rob_rs_rst_in,

    output logic [OP_W-1:0]   rs_alu_opcode_out,
    output logic [XLEN-1:0]   rs_alu_vj_out,
    output logic [XLEN-1:0]   rs_alu_vk_out,
    output logic [XLEN-1:0]   rs_alu_a_out,
    output logic [XLEN-1:0]   rs_alu_pc_out,
    output logic [ROB_W-1:0]  rs_alu_dest_out
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // A waiting tag is resolved by whichever bus carries it; tag 0 never matches.
    function automatic logic cdb_hit(
        input logic [ROB_W-1:0] q,
        input logic [ROB_W-1:0] alu_h,
        input logic [ROB_W-1:0] lsb_h
    );
        return (q != '0) && ((q == alu_h) || (q == lsb_h));
    endfunction

    // Only meaningful when cdb_hit is true; the ALU bus wins a duplicate tag.
    function automatic logic [XLEN-1:0] cdb_value(
        input logic [ROB_W-1:0] q,
        input logic [ROB_W-1:0] alu_h,
        input logic [XLEN-1:0]  alu_v,
        input logic [XLEN-1:0]  lsb_v
    );
        return (q == alu_h) ? alu_v : lsb_v;
    endfunction

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] busy_next;
    logic [RS_SIZE-1:0] ready;

    logic [OP_W-1:0]    ent_op   [RS_SIZE];
    logic [XLEN-1:0]    ent_vj   [RS_SIZE];
    logic [XLEN-1:0]    ent_vk   [RS_SIZE];
    logic [ROB_W-1:0]   ent_qj   [RS_SIZE];
    logic [ROB_W-1:0]   ent_qk   [RS_SIZE];
    logic [XLEN-1:0]    ent_a    [RS_SIZE];
    logic [XLEN-1:0]    ent_pc   [RS_SIZE];
    logic [ROB_W-1:0]   ent_dest [RS_SIZE];

    logic               vld_p0;
    logic [IDX_W-1:0]   sel_idx_p0;
    logic               free_vld_p0;
    logic [IDX_W-1:0]   free_idx_p0;
    logic               disp_fire_p0;

    // Stage p0: selection from registered state only.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (ent_qj[i] == '0) && (ent_qk[i] == '0);
        end
    end

    always_comb begin
        vld_p0      = 1'b0;
        sel_idx_p0  = '0;
        free_vld_p0 = 1'b0;
        free_idx_p0 = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                vld_p0     = 1'b1;
                sel_idx_p0 = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_vld_p0 = 1'b1;
                free_idx_p0 = IDX_W'(i);
            end
        end
    end

    assign rs_full_out  = &busy;
    assign disp_fire_p0 = disp_valid_in && free_vld_p0;

    always_comb begin
        busy_next = busy;
        if (vld_p0) begin
            busy_next[sel_idx_p0] = 1'b0;
        end
        if (disp_fire_p0) begin
            busy_next[free_idx_p0] = 1'b1;
        end
    end

    // Stage p1: entry payload. Captures touch busy entries, dispatch touches a free one,
    // so the two never write the same slot.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_rs_rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (cdb_hit(ent_qj[i], alu_cdb_h_in, lsb_cdb_h_in)) begin
                        ent_vj[i] <= cdb_value(ent_qj[i], alu_cdb_h_in,
                                               alu_cdb_result_in, lsb_cdb_result_in);
                        ent_qj[i] <= '0;
                    end
                    if (cdb_hit(ent_qk[i], alu_cdb_h_in, lsb_cdb_h_in)) begin
                        ent_vk[i] <= cdb_value(ent_qk[i], alu_cdb_h_in,
                                               alu_cdb_result_in, lsb_cdb_result_in);
                        ent_qk[i] <= '0;
                    end
                end
            end
            if (disp_fire_p0) begin
                ent_op[free_idx_p0]   <= disp_opcode_in;
                ent_a[free_idx_p0]    <= disp_a_in;
                ent_pc[free_idx_p0]   <= disp_pc_in;
                ent_dest[free_idx_p0] <= disp_dest_in;
                if (cdb_hit(disp_qj_in, alu_cdb_h_in, lsb_cdb_h_in)) begin
                    ent_vj[free_idx_p0] <= cdb_value(disp_qj_in, alu_cdb_h_in,
                                                     alu_cdb_result_in, lsb_cdb_result_in);
                    ent_qj[free_idx_p0] <= '0;
                end else begin
                    ent_vj[free_idx_p0] <= disp_vj_in;
                    ent_qj[free_idx_p0] <= disp_qj_in;
                end
                if (cdb_hit(disp_qk_in, alu_cdb_h_in, lsb_cdb_h_in)) begin
                    ent_vk[free_idx_p0] <= cdb_value(disp_qk_in, alu_cdb_h_in,
                                                     alu_cdb_result_in, lsb_cdb_result_in);
                    ent_qk[free_idx_p0] <= '0;
                end else begin
                    ent_vk[free_idx_p0] <= disp_vk_in;
                    ent_qk[free_idx_p0] <= disp_qk_in;
                end
            end
        end
    end

    // Stage p1: occupancy and the issue register facing the ALU.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy              <= '0;
            rs_alu_opcode_out <= NOP_OP;
            rs_alu_vj_out     <= '0;
            rs_alu_vk_out     <= '0;
            rs_alu_a_out      <= '0;
            rs_alu_pc_out     <= '0;
            rs_alu_dest_out   <= '0;
        end else if (rdy_in) begin
            if (rob_rs_rst_in) begin
                busy              <= '0;
                rs_alu_opcode_out <= NOP_OP;
            end else begin
                busy <= busy_next;
                if (vld_p0) begin
                    rs_alu_opcode_out <= ent_op[sel_idx_p0];
                    rs_alu_vj_out     <= ent_vj[sel_idx_p0];
                    rs_alu_vk_out     <= ent_vk[sel_idx_p0];
                    rs_alu_a_out      <= ent_a[sel_idx_p0];
                    rs_alu_pc_out     <= ent_pc[sel_idx_p0];
                    rs_alu_dest_out   <= ent_dest[sel_idx_p0];
                end else begin
                    rs_alu_opcode_out <= NOP_OP;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus a randomized run,
// all checked against a behavioural entry-list model of the station.
module tb_alu_reservation_station;

    localparam int         RS  = 8;
    localparam logic [5:0] NOP = 6'd0;

    logic        clk = 1'b0;
    logic        rst, rdy, dv, flush, full;
    logic [5:0]  d_op, o_op;
    logic [31:0] d_vj, d_vk, d_a, d_pc, acr, lcr;
    logic [3:0]  d_qj, d_qk, d_dest, ach, lch, o_dest;
    logic [31:0] o_vj, o_vk, o_a, o_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_reservation_station dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .disp_valid_in(dv), .disp_opcode_in(d_op),
        .disp_vj_in(d_vj), .disp_vk_in(d_vk), .disp_qj_in(d_qj), .disp_qk_in(d_qk),
        .disp_a_in(d_a), .disp_pc_in(d_pc), .disp_dest_in(d_dest),
        .rs_full_out(full),
        .alu_cdb_h_in(ach), .alu_cdb_result_in(acr),
        .lsb_cdb_h_in(lch), .lsb_cdb_result_in(lcr),
        .rob_rs_rst_in(flush),
        .rs_alu_opcode_out(o_op), .rs_alu_vj_out(o_vj), .rs_alu_vk_out(o_vk),
        .rs_alu_a_out(o_a), .rs_alu_pc_out(o_pc), .rs_alu_dest_out(o_dest)
    );

    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] vj, vk, a, pc;
        logic [3:0]  qj, qk, dest;
    } ent_t;

    ent_t        m [RS];
    logic [5:0]  e_op;
    logic [31:0] e_vj, e_vk, e_a, e_pc;
    logic [3:0]  e_dest;

    function automatic bit m_full();
        for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Resolve a waiting operand against the buses of this cycle, ALU bus first.
    function automatic logic [35:0] resolve(logic [3:0] q, logic [31:0] v);
        if (q != 4'd0 && q == ach) return {4'd0, acr};
        if (q != 4'd0 && q == lch) return {4'd0, lcr};
        return {q, v};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
        e_op = NOP; e_vj = '0; e_vk = '0; e_a = '0; e_pc = '0; e_dest = '0;
    endtask

    task automatic model_step();
        ent_t nx [RS];
        int   iss = -1;
        int   fr  = -1;
        if (!rdy) return;
        nx = m;
        if (flush) begin
            for (int i = 0; i < RS; i++) nx[i].busy = 1'b0;
            e_op = NOP;
            m = nx;
            return;
        end
        for (int i = 0; i < RS; i++) begin
            if (iss < 0 && m[i].busy && m[i].qj == 0 && m[i].qk == 0) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (nx[i].busy) begin
                {nx[i].qj, nx[i].vj} = resolve(nx[i].qj, nx[i].vj);
                {nx[i].qk, nx[i].vk} = resolve(nx[i].qk, nx[i].vk);
            end
        end
        if (dv && fr >= 0) begin
            nx[fr].busy = 1'b1; nx[fr].op = d_op; nx[fr].a = d_a;
            nx[fr].pc = d_pc; nx[fr].dest = d_dest;
            {nx[fr].qj, nx[fr].vj} = resolve(d_qj, d_vj);
            {nx[fr].qk, nx[fr].vk} = resolve(d_qk, d_vk);
        end
        if (iss >= 0) begin
            e_op = m[iss].op; e_vj = m[iss].vj; e_vk = m[iss].vk;
            e_a = m[iss].a; e_pc = m[iss].pc; e_dest = m[iss].dest;
            nx[iss].busy = 1'b0;
        end else begin
            e_op = NOP;
        end
        m = nx;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dv = 0; flush = 0; rdy = 1; ach = 0; lch = 0; acr = 0; lcr = 0;
        d_op = 0; d_vj = 0; d_vk = 0; d_qj = 0; d_qk = 0; d_a = 0; d_pc = 0; d_dest = 0;
    endtask

    task automatic set_disp(logic [5:0] op, logic [31:0] vj, logic [3:0] qj,
                            logic [31:0] vk, logic [3:0] qk, logic [3:0] dest);
        dv = 1; d_op = op; d_vj = vj; d_qj = qj; d_vk = vk; d_qk = qk; d_dest = dest;
        d_a = $urandom; d_pc = $urandom;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL reset_op got %0d want %0d", o_op, NOP); end
        checks++; if (o_dest !== 4'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", o_dest); end
        checks++; if ({o_vj, o_vk, o_a, o_pc} !== 128'd0) begin errors++; $display("FAIL reset_data got %0h want 0", {o_vj, o_vk, o_a, o_pc}); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        for (int k = 0; k < 3; k++) begin set_disp(6'd3, 0, 4'd9, 0, 4'd0, 4'(k + 1)); tick(); end
        set_disp(6'd1, 32'd11, 4'd0, 32'd12, 4'd0, 4'd6); tick();
        dv = 0; tick();
        checks++; if (o_op !== 6'd1 || o_dest !== 4'd6) begin errors++; $display("FAIL pre_reset_issue got op %0d dest %0d want op 1 dest 6", o_op, o_dest); end
        #2 rst = 1;
        #1;
        checks++; if (o_op !== NOP || o_dest !== 4'd0 || o_vj !== 32'd0) begin errors++; $display("FAIL async_reset got op %0d dest %0d vj %0h want NOP/0/0", o_op, o_dest, o_vj); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL async_reset_full got %0b want 0", full); end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        // After reset all eight slots must be free again.
        for (int k = 0; k < 8; k++) begin
            set_disp(6'd3, 0, 4'd9, 0, 4'd0, 4'(k + 1)); tick();
            if (k == 6) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL post_reset_full7 got %0b want 0", full); end
            end
        end
        dv = 0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL post_reset_full8 got %0b want 1", full); end
        flush = 1; tick(); flush = 0;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL flush_clears_full got %0b want 0", full); end
    endtask

    task automatic test_ready_dispatch();
        set_disp(6'd1, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3); tick();
        dv = 0;
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL ready_edge1 got %0d want %0d", o_op, NOP); end
        tick();
        checks++; if (o_op !== 6'd1 || o_vj !== 32'd5 || o_vk !== 32'd7 || o_dest !== 4'd3) begin
            errors++; $display("FAIL ready_issue got op %0d vj %0d vk %0d dest %0d want 1/5/7/3", o_op, o_vj, o_vk, o_dest); end
        checks++; if (o_a !== e_a || o_pc !== e_pc) begin errors++; $display("FAIL ready_a_pc got %0h/%0h want %0h/%0h", o_a, o_pc, e_a, e_pc); end
        tick();
        checks++; if (o_op !== NOP || o_dest !== 4'd3) begin errors++; $display("FAIL ready_one_cycle got op %0d dest %0d want NOP dest 3", o_op, o_dest); end
    endtask

    task automatic test_cdb();
        set_disp(6'd2, 32'd0, 4'd4, 32'd1, 4'd0, 4'd5); tick();
        dv = 0; tick();
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL cdb_wait got %0d want %0d", o_op, NOP); end
        ach = 4; acr = 32'd10; tick(); ach = 0;
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL cdb_capture_edge got %0d want %0d", o_op, NOP); end
        tick();
        checks++; if (o_op !== 6'd2 || o_vj !== 32'd10 || o_vk !== 32'd1 || o_dest !== 4'd5) begin
            errors++; $display("FAIL cdb_alu got op %0d vj %0d vk %0d dest %0d want 2/10/1/5", o_op, o_vj, o_vk, o_dest); end
        set_disp(6'd2, 32'd20, 4'd0, 32'd0, 4'd7, 4'd6); tick();
        dv = 0; lch = 7; lcr = 32'd33; tick(); lch = 0;
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL cdb_lsb_edge got %0d want %0d", o_op, NOP); end
        tick();
        checks++; if (o_op !== 6'd2 || o_vj !== 32'd20 || o_vk !== 32'd33 || o_dest !== 4'd6) begin
            errors++; $display("FAIL cdb_lsb got op %0d vj %0d vk %0d dest %0d want 2/20/33/6", o_op, o_vj, o_vk, o_dest); end
        set_disp(6'd3, 32'd0, 4'd6, 32'd0, 4'd11, 4'd8);
        ach = 6; acr = 32'd44; lch = 11; lcr = 32'd55; tick();
        dv = 0; ach = 0; lch = 0; tick();
        checks++; if (o_op !== 6'd3 || o_vj !== 32'd44 || o_vk !== 32'd55 || o_dest !== 4'd8) begin
            errors++; $display("FAIL cdb_forward got op %0d vj %0d vk %0d dest %0d want 3/44/55/8", o_op, o_vj, o_vk, o_dest); end
        set_disp(6'd4, 32'd0, 4'd12, 32'd2, 4'd0, 4'd9); tick();
        dv = 0; ach = 12; acr = 32'd100; lch = 12; lcr = 32'd200; tick();
        ach = 0; lch = 0; tick();
        checks++; if (o_op !== 6'd4 || o_vj !== 32'd100) begin errors++; $display("FAIL cdb_alu_priority got op %0d vj %0d want 4/100", o_op, o_vj); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 8; k++) begin set_disp(6'd5, 0, 4'd2, 32'(k), 4'd0, 4'(k + 1)); tick(); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after8 got %0b want 1", full); end
        set_disp(6'd6, 32'd1, 4'd0, 32'd1, 4'd0, 4'd15); tick();
        dv = 0;
        checks++; if (full !== 1'b1 || o_op !== NOP) begin errors++; $display("FAIL full_ninth got full %0b op %0d want 1/NOP", full, o_op); end
        ach = 2; acr = 32'd77; tick(); ach = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (o_op !== 6'd5 || o_dest !== 4'(k + 1) || o_vj !== 32'd77 || o_vk !== 32'(k)) begin
                errors++; $display("FAIL full_order_%0d got op %0d dest %0d vj %0d vk %0d want 5/%0d/77/%0d", k, o_op, o_dest, o_vj, o_vk, k + 1, k); end
            if (k == 0) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_drop got %0b want 0", full); end
            end
        end
        tick();
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL full_ninth_discarded got %0d want %0d", o_op, NOP); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) begin set_disp(6'd5, 0, 4'd3, 0, 4'd0, 4'(k + 1)); tick(); end
        dv = 0; ach = 3; acr = 32'd9; tick(); ach = 0;
        tick();
        checks++; if (o_op !== 6'd5 || o_dest !== 4'd1) begin errors++; $display("FAIL flush_pre got op %0d dest %0d want 5/1", o_op, o_dest); end
        flush = 1; set_disp(6'd7, 32'd1, 4'd0, 32'd2, 4'd0, 4'd13); tick();
        flush = 0; dv = 0;
        checks++; if (o_op !== NOP || full !== 1'b0) begin errors++; $display("FAIL flush_edge got op %0d full %0b want NOP/0", o_op, full); end
        tick();
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL flush_empty got op %0d want %0d", o_op, NOP); end
    endtask

    task automatic test_rdy();
        set_disp(6'd9, 32'd0, 4'd8, 32'd3, 4'd0, 4'd10); tick();
        set_disp(6'd8, 32'd1, 4'd0, 32'd2, 4'd0, 4'd7); tick();
        rdy = 0; ach = 8; acr = 32'd99;
        set_disp(6'd10, 32'd1, 4'd0, 32'd1, 4'd0, 4'd14);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_op !== NOP) begin errors++; $display("FAIL rdy_low_%0d got op %0d want %0d", k, o_op, NOP); end
        end
        rdy = 1; ach = 0; dv = 0; tick();
        checks++; if (o_op !== 6'd8 || o_dest !== 4'd7) begin errors++; $display("FAIL rdy_resume got op %0d dest %0d want 8/7", o_op, o_dest); end
        tick();
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL rdy_no_capture got op %0d want %0d", o_op, NOP); end
        ach = 8; acr = 32'd99; tick(); ach = 0; tick();
        checks++; if (o_op !== 6'd9 || o_vj !== 32'd99 || o_dest !== 4'd10) begin
            errors++; $display("FAIL rdy_late_capture got op %0d vj %0d dest %0d want 9/99/10", o_op, o_vj, o_dest); end
        tick();
        checks++; if (o_op !== NOP) begin errors++; $display("FAIL rdy_dispatch_ignored got op %0d want %0d", o_op, NOP); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rdy   = ($urandom % 8) != 0;
            flush = ($urandom % 32) == 0;
            dv    = ($urandom % 3) != 0;
            d_op  = 6'($urandom_range(1, 63));
            d_qj  = ($urandom % 2) ? 4'($urandom_range(1, 7)) : 4'd0;
            d_qk  = ($urandom % 2) ? 4'($urandom_range(1, 7)) : 4'd0;
            d_dest = 4'($urandom_range(1, 15));
            d_vj = $urandom; d_vk = $urandom; d_a = $urandom; d_pc = $urandom;
            ach  = ($urandom % 2) ? 4'($urandom_range(1, 7)) : 4'd0;
            lch  = ($urandom % 2) ? 4'($urandom_range(1, 7)) : 4'd0;
            acr  = $urandom; lcr = $urandom;
            tick();
            checks++; if (o_op !== e_op) begin errors++; $display("FAIL rand_op cycle %0d got %0d want %0d", c, o_op, e_op); end
            checks++; if ({o_vj, o_vk, o_a, o_pc, o_dest} !== {e_vj, e_vk, e_a, e_pc, e_dest}) begin
                errors++; $display("FAIL rand_data cycle %0d got %0h want %0h", c, {o_vj, o_vk, o_a, o_pc, o_dest}, {e_vj, e_vk, e_a, e_pc, e_dest}); end
            checks++; if (full !== m_full()) begin errors++; $display("FAIL rand_full cycle %0d got %0b want %0b", c, full, m_full()); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_cdb();
        test_full();
        test_flush();
        test_rdy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
